// File: rtl/pll_clock_manager_if.sv
// Lock input, increment programming and status/tick outputs of pll_clock_manager.
// The supervisor takes the slave side; whatever drives lock and increments takes the master side.
interface pll_clock_manager_if #(
    parameter int unsigned ACC_WIDTH      = 32,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned LOSS_CNT_WIDTH = 8
);
    logic                          pll_locked;
    logic [NUM_CH*ACC_WIDTH-1:0]   inc_i;
    logic                          inc_load;
    logic                          rst_out;
    logic                          ready;
    logic [NUM_CH-1:0]             tick;
    logic [LOSS_CNT_WIDTH-1:0]     loss_count;

    modport master (
        output pll_locked, inc_i, inc_load,
        input  rst_out, ready, tick, loss_count
    );

    modport slave (
        input  pll_locked, inc_i, inc_load,
        output rst_out, ready, tick, loss_count
    );
endinterface

// File: rtl/pll_clock_manager.sv
// PLL lock supervisor: synchronises and qualifies lock, holds downstream reset until
// lock is stable, then emits per-channel fractional-rate tick strobes from phase accumulators.
module pll_clock_manager #(
    parameter int unsigned ACC_WIDTH          = 32,
    parameter int unsigned NUM_CH             = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned LOSS_CNT_WIDTH     = 8,
    parameter int unsigned INC_DEFAULT        = 524005
) (
    input  logic                 clock,
    input  logic                 reset,
    pll_clock_manager_if.slave   bus
);
    localparam int unsigned STAB_W = $clog2(LOCK_STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        STABILISE,
        RUN,
        LOST
    } state_t;

    state_t                     state;
    state_t                     state_next;
    logic [STAB_W-1:0]          stab_cnt;
    logic [STAB_W-1:0]          stab_next;
    logic                       loss_inc;
    logic                       sync1;
    logic                       lk_s;
    logic                       rst_q;
    logic                       ready_q;
    logic [NUM_CH-1:0]          tick_q;
    logic [LOSS_CNT_WIDTH-1:0]  loss_q;
    logic [ACC_WIDTH-1:0]       acc [NUM_CH];
    logic [ACC_WIDTH-1:0]       inc [NUM_CH];
    logic [ACC_WIDTH:0]         sum [NUM_CH];

    assign bus.rst_out    = rst_q;
    assign bus.ready      = ready_q;
    assign bus.tick       = tick_q;
    assign bus.loss_count = loss_q;

    always_comb begin
        state_next = state;
        stab_next  = stab_cnt;
        loss_inc   = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (lk_s) begin
                    state_next = STABILISE;
                    stab_next  = '0;
                end
            end
            STABILISE: begin
                if (!lk_s) begin
                    state_next = WAIT_LOCK;
                end else if (stab_cnt == STAB_LAST) begin
                    state_next = RUN;
                end else begin
                    stab_next = stab_cnt + STAB_W'(1);
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_next = LOST;
                    loss_inc   = 1'b1;
                end
            end
            LOST:    state_next = WAIT_LOCK;
            default: state_next = WAIT_LOCK;
        endcase
    end

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            sum[c] = {1'b0, acc[c]} + {1'b0, inc[c]};
        end
    end

    // rst_out/ready/tick are registered from the next state so they change on the same
    // edge as the state flops, and a tick can never coincide with rst_out=1.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= WAIT_LOCK;
            stab_cnt <= '0;
            sync1    <= 1'b0;
            lk_s     <= 1'b0;
            rst_q    <= 1'b1;
            ready_q  <= 1'b0;
            tick_q   <= '0;
            loss_q   <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                inc[c] <= ACC_WIDTH'(INC_DEFAULT);
            end
        end else begin
            sync1    <= bus.pll_locked;
            lk_s     <= sync1;
            state    <= state_next;
            stab_cnt <= stab_next;
            rst_q    <= (state_next != RUN);
            ready_q  <= (state_next == RUN);
            if (loss_inc && (loss_q != '1)) begin
                loss_q <= loss_q + LOSS_CNT_WIDTH'(1);
            end
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (bus.inc_load) begin
                    inc[c] <= bus.inc_i[c*ACC_WIDTH +: ACC_WIDTH];
                end
                if (state == RUN) begin
                    acc[c] <= sum[c][ACC_WIDTH-1:0];
                end else begin
                    acc[c] <= '0;
                end
                tick_q[c] <= (state == RUN) && (state_next == RUN) && sum[c][ACC_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_pll_clock_manager.sv
// Directed bench for pll_clock_manager: lock qualification, tick cadence, increment
// reload, lock loss/saturation, glitch during stabilisation and mid-run reset.
module tb_pll_clock_manager;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pll_clock_manager_if #(.ACC_WIDTH(8), .NUM_CH(2), .LOSS_CNT_WIDTH(8)) bus ();

    pll_clock_manager #(
        .ACC_WIDTH(8),
        .NUM_CH(2),
        .LOCK_STABLE_CYCLES(4),
        .LOSS_CNT_WIDTH(8),
        .INC_DEFAULT(64)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, input logic want, input int budget);
        int n;
        n = 0;
        while (bus.ready !== want && n < budget) begin
            step();
            n++;
        end
        check(tag, bus.ready, want);
    endtask

    initial begin
        int cnt0;
        int cnt1;
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        bus.pll_locked = 1'b0;
        bus.inc_load   = 1'b0;
        bus.inc_i      = '0;
        step();
        step();
        check("reset_rst_out", bus.rst_out, 1);
        check("reset_ready", bus.ready, 0);
        check("reset_tick", bus.tick, 0);
        check("reset_loss", bus.loss_count, 0);

        // Lock qualification: 2 sync + 4 stabilise + 1 transition edges.
        rst            = 1'b0;
        bus.pll_locked = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("lock_rst_out_k%0d", k), bus.rst_out, (k < 7) ? 1 : 0);
            check($sformatf("lock_ready_k%0d", k), bus.ready, (k < 7) ? 0 : 1);
        end
        check("run0_tick", bus.tick, 0);

        // Default increment 64/256: both channels tick on R4, R8, R12.
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("tick64_r%0d", k), bus.tick, (k % 4 == 0) ? 3 : 0);
        end

        // ch1 -> 96: 3 ticks every 8 cycles; ch0 stays at 2 per 8.
        bus.inc_i    = {8'd96, 8'd64};
        bus.inc_load = 1'b1;
        step();
        bus.inc_load = 1'b0;
        step();
        for (int w = 0; w < 3; w++) begin
            cnt0 = 0;
            cnt1 = 0;
            for (int j = 0; j < 8; j++) begin
                step();
                cnt0 += int'(bus.tick[0]);
                cnt1 += int'(bus.tick[1]);
            end
            check($sformatf("win%0d_ch0", w), cnt0, 2);
            check($sformatf("win%0d_ch1", w), cnt1, 3);
        end

        // Reset in RUN with a simultaneous load: reset wins, increments return to 64.
        rst          = 1'b1;
        bus.inc_i    = {8'd200, 8'd200};
        bus.inc_load = 1'b1;
        step();
        check("rst_run_rst_out", bus.rst_out, 1);
        check("rst_run_ready", bus.ready, 0);
        check("rst_run_tick", bus.tick, 0);
        check("rst_run_loss", bus.loss_count, 0);
        rst          = 1'b0;
        bus.inc_load = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check($sformatf("relock_rst_out_k%0d", k), bus.rst_out, (k < 7) ? 1 : 0);
        end
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("tick_after_rst_r%0d", k), bus.tick, (k % 4 == 0) ? 3 : 0);
            if (k == 9) bus.pll_locked = 1'b0;
        end

        // Lock falls after R9: LOST lands on the edge that would have produced a tick.
        step();
        check("loss_r10_rst_out", bus.rst_out, 0);
        step();
        check("loss_r11_ready", bus.ready, 1);
        check("loss_r11_tick", bus.tick, 0);
        step();
        check("loss_rst_out", bus.rst_out, 1);
        check("loss_ready", bus.ready, 0);
        check("loss_tick", bus.tick, 0);
        check("loss_count_1", bus.loss_count, 1);

        for (int i = 2; i <= 300; i++) begin
            bus.pll_locked = 1'b1;
            wait_ready($sformatf("drop%0d_up", i), 1'b1, 20);
            bus.pll_locked = 1'b0;
            wait_ready($sformatf("drop%0d_down", i), 1'b0, 10);
            if (i == 254) check("loss_count_254", bus.loss_count, 254);
        end
        check("loss_count_sat", bus.loss_count, 255);
        step();
        step();

        // One-cycle lock dropout during STABILISE restarts qualification.
        bus.pll_locked = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            check($sformatf("glitch_rst_out_k%0d", k), bus.rst_out, (k < 11) ? 1 : 0);
            if (k == 3) bus.pll_locked = 1'b0;
            if (k == 4) bus.pll_locked = 1'b1;
        end
        check("glitch_ready", bus.ready, 1);
        check("glitch_loss_held", bus.loss_count, 255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
